// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// then shifts a command byte out on device-generated clocks and checks the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       tx_busy,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQUEST   = 3'd2,
    ST_BITS      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  // Odd parity bit for the frame: makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t           state_r, state_nxt;
  logic [7:0]       data_r, data_nxt;
  logic             parity_r, parity_nxt;
  logic [INH_W-1:0] inh_cnt_r, inh_cnt_nxt;
  logic [3:0]       edge_cnt_r, edge_cnt_nxt;
  logic [TO_W-1:0]  to_cnt_r, to_cnt_nxt;
  logic             clk_s1_r, clk_s2_r, dat_s1_r, dat_s2_r;
  logic             clk_oe_r, clk_oe_nxt, dat_oe_r, dat_oe_nxt;
  logic             ready_r, ready_nxt, busy_r, busy_nxt;
  logic             done_r, done_nxt, error_r, error_nxt;
  logic             clk_fall_s;
  logic [3:0]       edge_num_s;

  assign clk_fall_s = clk_s2_r & ~clk_s1_r;
  assign edge_num_s = edge_cnt_r + 4'd1;

  assign tx_ready   = ready_r;
  assign tx_busy    = busy_r;
  assign tx_done    = done_r;
  assign tx_error   = error_r;
  assign ps2_clk_oe = clk_oe_r;
  assign ps2_dat_oe = dat_oe_r;

  // Two-flop synchronizers for the raw pad levels; idle bus reads as high.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_r <= 1'b1;
      clk_s2_r <= 1'b1;
      dat_s1_r <= 1'b1;
      dat_s2_r <= 1'b1;
    end else begin
      clk_s1_r <= PS2_CLK;
      clk_s2_r <= clk_s1_r;
      dat_s1_r <= PS2_DAT;
      dat_s2_r <= dat_s1_r;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      data_r     <= 8'h00;
      parity_r   <= 1'b0;
      inh_cnt_r  <= '0;
      edge_cnt_r <= 4'd0;
      to_cnt_r   <= '0;
      clk_oe_r   <= 1'b0;
      dat_oe_r   <= 1'b0;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      data_r     <= data_nxt;
      parity_r   <= parity_nxt;
      inh_cnt_r  <= inh_cnt_nxt;
      edge_cnt_r <= edge_cnt_nxt;
      to_cnt_r   <= to_cnt_nxt;
      clk_oe_r   <= clk_oe_nxt;
      dat_oe_r   <= dat_oe_nxt;
      ready_r    <= ready_nxt;
      busy_r     <= busy_nxt;
      done_r     <= done_nxt;
      error_r    <= error_nxt;
    end
  end

  // Next-state logic; output values are computed for the state being entered.
  always_comb begin
    state_nxt    = state_r;
    data_nxt     = data_r;
    parity_nxt   = parity_r;
    inh_cnt_nxt  = inh_cnt_r;
    edge_cnt_nxt = edge_cnt_r;
    to_cnt_nxt   = to_cnt_r;
    dat_oe_nxt   = 1'b0;
    done_nxt     = 1'b0;
    error_nxt    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tx_valid && ready_r) begin
          data_nxt    = tx_data;
          parity_nxt  = odd_parity(tx_data);
          inh_cnt_nxt = '0;
          state_nxt   = ST_INHIBIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt_r == INH_LAST) begin
          inh_cnt_nxt = '0;
          dat_oe_nxt  = 1'b1;
          state_nxt   = ST_REQUEST;
        end else begin
          inh_cnt_nxt = inh_cnt_r + {{(INH_W-1){1'b0}}, 1'b1};
        end
      end
      ST_REQUEST: begin
        // Start bit stays driven until the first device falling edge.
        dat_oe_nxt   = 1'b1;
        edge_cnt_nxt = 4'd0;
        to_cnt_nxt   = '0;
        state_nxt    = ST_BITS;
      end
      ST_BITS: begin
        dat_oe_nxt = dat_oe_r;
        if (to_cnt_r == TO_LAST) begin
          dat_oe_nxt = 1'b0;
          error_nxt  = 1'b1;
          state_nxt  = ST_IDLE;
        end else begin
          to_cnt_nxt = to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
          if (clk_fall_s) begin
            edge_cnt_nxt = edge_num_s;
            case (edge_num_s)
              4'd1, 4'd2, 4'd3, 4'd4,
              4'd5, 4'd6, 4'd7, 4'd8: dat_oe_nxt = ~data_r[edge_cnt_r[2:0]];
              4'd9:  dat_oe_nxt = ~parity_r;
              4'd10: dat_oe_nxt = 1'b0;
              4'd11: begin
                dat_oe_nxt = 1'b0;
                if (!dat_s2_r) begin
                  state_nxt = ST_WAIT_IDLE;
                end else begin
                  error_nxt = 1'b1;
                  state_nxt = ST_IDLE;
                end
              end
              default: dat_oe_nxt = 1'b0;
            endcase
          end else begin
            edge_cnt_nxt = edge_cnt_r;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (to_cnt_r == TO_LAST) begin
          error_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end else if (clk_s2_r && dat_s2_r) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          to_cnt_nxt = to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    clk_oe_nxt = (state_nxt == ST_INHIBIT) || (state_nxt == ST_REQUEST);
    busy_nxt   = (state_nxt != ST_IDLE);
    // Ready reappears one cycle after a done/error pulse.
    ready_nxt  = (state_nxt == ST_IDLE) && !done_nxt && !error_nxt;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the pads.
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int TOUT = 2000;
  localparam int HALF = 20;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error, tx_busy;
  logic       PS2_CLK, PS2_DAT, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, bad_ready = 0, last_err_cyc = 0;
  logic prev_pulse = 1'b0;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOUT)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error), .tx_busy(tx_busy),
    .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT), .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
  );

  // Open-drain pads: either side may pull low.
  assign PS2_CLK = ~(ps2_clk_oe | dev_clk_low);
  assign PS2_DAT = ~(ps2_dat_oe | dev_dat_low);

  always #5 CLOCK_50 = ~CLOCK_50;

  // Pulse monitor sampled away from the active edge.
  always @(negedge CLOCK_50) begin
    cyc = cyc + 1;
    if (tx_done) done_cnt = done_cnt + 1;
    if (tx_error) begin err_cnt = err_cnt + 1; last_err_cyc = cyc; end
    if (tx_done && tx_error) both_cnt = both_cnt + 1;
    if ((tx_done || tx_error) && tx_ready) bad_ready = bad_ready + 1;
    if (prev_pulse && !tx_ready && reset_n) bad_ready = bad_ready + 1;
    prev_pulse = tx_done | tx_error;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a byte and return at the first negedge after it was accepted.
  task automatic host_request(input logic [7:0] d, input bit keep_valid, input logic [7:0] d_after);
    int guard = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && guard < 200) begin @(negedge CLOCK_50); guard++; end
    @(negedge CLOCK_50);
    if (keep_valid) tx_data = d_after;
    else tx_valid = 1'b0;
  endtask

  // Device side: measure inhibit/request, then clock n_edges and sample DAT before each fall.
  task automatic dev_frame(input int n_edges, input bit ack, output logic [10:0] bits,
                           output int inh_cnt, output int req_cnt);
    int guard = 0;
    bits = 11'h000; inh_cnt = 0; req_cnt = 0;
    while (!ps2_clk_oe && guard < 1000) begin @(negedge CLOCK_50); guard++; end
    while (ps2_clk_oe && !ps2_dat_oe && guard < 1000) begin inh_cnt++; @(negedge CLOCK_50); guard++; end
    while (ps2_clk_oe && ps2_dat_oe && guard < 1000) begin req_cnt++; @(negedge CLOCK_50); guard++; end
    for (int k = 0; k < n_edges; k++) begin
      repeat (HALF) @(negedge CLOCK_50);
      bits[k] = PS2_DAT;
      if (k == 10 && ack) begin dev_dat_low = 1'b1; repeat (5) @(negedge CLOCK_50); end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge CLOCK_50);
      if (k < n_edges - 1) dev_clk_low = 1'b0;
    end
    if (n_edges == 11) begin
      dev_clk_low = 1'b0;
      repeat (5) @(negedge CLOCK_50);
      dev_dat_low = 1'b0;
    end
  endtask

  // Full acknowledged transfer of one byte with a hand-computed parity bit.
  task automatic send_and_check(input logic [7:0] d, input logic par, input string tag);
    logic [10:0] bits;
    int inh, req, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    host_request(d, 1'b0, 8'h00);
    dev_frame(11, 1'b1, bits, inh, req);
    repeat (30) @(negedge CLOCK_50);
    check({tag, "_frame"}, {21'd0, bits}, {21'd0, 1'b1, par, d, 1'b0});
    check({tag, "_inhibit"}, inh, INH);
    check({tag, "_request"}, req, 1);
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_noerr"}, err_cnt - e0, 0);
    check({tag, "_ready"}, {30'd0, tx_ready, tx_busy}, 32'd2);
  endtask

  initial begin
    logic [10:0] bits;
    int inh, req, d0, e0, guard, req_cyc, dt;

    #1 reset_n = 1'b0;
    #1 check("reset_outputs", {26'd0, ps2_clk_oe, ps2_dat_oe, tx_ready, tx_busy, tx_done, tx_error}, 32'h08);
    repeat (3) @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    check("idle_outputs", {26'd0, ps2_clk_oe, ps2_dat_oe, tx_ready, tx_busy, tx_done, tx_error}, 32'h08);

    // Nominal byte and parity sweep.
    send_and_check(8'hED, 1'b1, "ed");
    send_and_check(8'h00, 1'b1, "p00");
    send_and_check(8'h01, 1'b0, "p01");
    send_and_check(8'hFF, 1'b1, "pff");
    send_and_check(8'hF4, 1'b0, "pf4");

    // Missing ACK: DAT left high at clock 11.
    d0 = done_cnt; e0 = err_cnt;
    host_request(8'h3C, 1'b0, 8'h00);
    dev_frame(11, 1'b0, bits, inh, req);
    repeat (30) @(negedge CLOCK_50);
    check("nack_error", err_cnt - e0, 1);
    check("nack_nodone", done_cnt - d0, 0);
    check("nack_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    check("nack_ready", {31'd0, tx_ready}, 1);

    // Device never clocks: timeout after release of CLK.
    d0 = done_cnt; e0 = err_cnt; guard = 0;
    host_request(8'h5A, 1'b0, 8'h00);
    while (!(ps2_clk_oe && ps2_dat_oe) && guard < 1000) begin @(negedge CLOCK_50); guard++; end
    req_cyc = cyc;
    guard = 0;
    while (err_cnt == e0 && guard < TOUT + 100) begin @(negedge CLOCK_50); guard++; end
    dt = last_err_cyc - req_cyc;
    check("timeout_window", {31'd0, (dt >= TOUT - 3) && (dt <= TOUT + 3)}, 1);
    check("timeout_error", err_cnt - e0, 1);
    @(negedge CLOCK_50);
    check("timeout_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    check("timeout_nodone", done_cnt - d0, 0);
    check("timeout_ready", {31'd0, tx_ready}, 1);

    // Reset during edge 5 of a 0x00 frame (dat_oe low-driving for data bit 4).
    d0 = done_cnt; e0 = err_cnt;
    host_request(8'h00, 1'b0, 8'h00);
    dev_frame(5, 1'b0, bits, inh, req);
    check("pre_reset_dat_oe", {31'd0, ps2_dat_oe}, 1);
    #2 reset_n = 1'b0;
    #1 check("async_reset_lines", {28'd0, ps2_clk_oe, ps2_dat_oe, tx_ready, tx_busy}, 32'h2);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    check("reset_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    send_and_check(8'hFF, 1'b1, "post_reset");

    // tx_valid held with new data while busy.
    d0 = done_cnt;
    host_request(8'h55, 1'b1, 8'hAA);
    dev_frame(11, 1'b1, bits, inh, req);
    check("hold_first_frame", {21'd0, bits}, {21'd0, 1'b1, 1'b1, 8'h55, 1'b0});
    guard = 0;
    while (!ps2_clk_oe && guard < 200) begin @(negedge CLOCK_50); guard++; end
    tx_valid = 1'b0;
    dev_frame(11, 1'b1, bits, inh, req);
    repeat (30) @(negedge CLOCK_50);
    check("hold_second_frame", {21'd0, bits}, {21'd0, 1'b1, 1'b1, 8'hAA, 1'b0});
    check("hold_done_count", done_cnt - d0, 2);

    check("no_done_and_error", both_cnt, 0);
    check("ready_after_pulse", bad_ready, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
